// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: forms the RV32/RV64 immediate from the raw instruction
// and passes it downstream through a 2-entry skid buffer with valid/ready on both sides.

package arriskv_pkg;
    typedef enum logic [3:0] {
        InstrNone,
        InstrR,
        InstrI,
        InstrIJ,
        InstrIL,
        InstrS,
        InstrB,
        InstrU,
        InstrJ,
        InstrIS
    } instr_type_t;
endpackage

module imm_gen_pipe
    import arriskv_pkg::*;
#(
    parameter int unsigned wd_regs_p = 32,
    parameter int unsigned wd_tag_p  = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [31:0]          i_instr,
    input  instr_type_t          i_instr_type,
    input  logic                 i_csr_uimm,
    input  logic [wd_tag_p-1:0]  i_tag,
    input  logic                 i_flush,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [wd_regs_p-1:0] o_imm,
    output logic [wd_tag_p-1:0]  o_tag,
    output logic                 o_err
);

    if (wd_regs_p != 32 && wd_regs_p != 64) begin : g_bad_width
        $error("imm_gen_pipe: wd_regs_p must be 32 or 64");
    end

    typedef logic [wd_regs_p-1:0] reg_t;

    typedef struct packed {
        logic                valid;
        logic                err;
        logic [wd_tag_p-1:0] tag;
        reg_t                imm;
    } entry_t;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t new_entry;

    logic [31:0] imm32;
    logic        imm_sext;
    logic        new_err;
    logic        in_xfer;
    logic        out_xfer;

    // The opcode field never contributes to any immediate.
    logic unused_opcode;
    assign unused_opcode = ^i_instr[6:0];

    // Every immediate fits in 32 bits; imm_sext says whether bit 31 extends upward.
    always_comb begin
        imm32    = '0;
        imm_sext = 1'b0;
        new_err  = 1'b0;
        case (i_instr_type)
            InstrI: begin
                if (i_csr_uimm) begin
                    imm32 = {27'b0, i_instr[19:15]};
                end else begin
                    imm32    = {{20{i_instr[31]}}, i_instr[31:20]};
                    imm_sext = 1'b1;
                end
            end
            InstrIJ, InstrIL: begin
                imm32    = {{20{i_instr[31]}}, i_instr[31:20]};
                imm_sext = 1'b1;
            end
            InstrS: begin
                imm32    = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
                imm_sext = 1'b1;
            end
            InstrB: begin
                imm32    = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                            i_instr[11:8], 1'b0};
                imm_sext = 1'b1;
            end
            InstrU: begin
                imm32    = {i_instr[31:12], 12'b0};
                imm_sext = 1'b1;
            end
            InstrJ: begin
                imm32    = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                            i_instr[30:21], 1'b0};
                imm_sext = 1'b1;
            end
            InstrIS: begin
                if (wd_regs_p == 64) begin
                    imm32 = {26'b0, i_instr[25:20]};
                end else begin
                    // shamt[5] set on RV32 is an illegal shift.
                    imm32   = {27'b0, i_instr[24:20]};
                    new_err = i_instr[25];
                end
            end
            default: begin
                imm32    = '0;
                imm_sext = 1'b0;
                new_err  = 1'b0;
            end
        endcase
    end

    always_comb begin
        new_entry       = '0;
        new_entry.valid = 1'b1;
        new_entry.err   = new_err;
        new_entry.tag   = i_tag;
        new_entry.imm   = imm_sext ? reg_t'($signed(imm32)) : reg_t'(imm32);
    end

    // Ready depends only on registered state, never on i_ready.
    assign o_ready  = ~skid_q.valid;
    assign in_xfer  = i_valid & o_ready;
    assign out_xfer = main_q.valid & i_ready;

    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (i_flush) begin
            main_d.valid = 1'b0;
            skid_d.valid = 1'b0;
        end else if (out_xfer) begin
            if (skid_q.valid) begin
                // Skid full implies o_ready=0, so no input can arrive this cycle.
                main_d       = skid_q;
                skid_d.valid = 1'b0;
            end else if (in_xfer) begin
                main_d = new_entry;
            end else begin
                main_d.valid = 1'b0;
            end
        end else if (in_xfer) begin
            if (main_q.valid) begin
                skid_d = new_entry;
            end else begin
                main_d = new_entry;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign o_valid = main_q.valid;
    assign o_imm   = main_q.imm;
    assign o_tag   = main_q.tag;
    assign o_err   = main_q.err;

    skid_implies_main: assert property (
        @(posedge i_clk) disable iff (i_rst) skid_q.valid |-> main_q.valid
    );

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: one W=32 and one W=64 instance, directed vectors with
// hand-computed immediates pushed on accept and popped by per-instance monitors.

module tb_imm_gen_pipe;
    import arriskv_pkg::*;

    typedef struct {
        logic [63:0] imm;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // W=32 instance signals
    logic        v32, ordy32, flush32, ov32, rdy32, err32, uimm32;
    logic [31:0] instr32, imm32;
    instr_type_t typ32;
    logic [4:0]  tag32, otag32;
    logic [63:0] eimm32;
    logic        eerr32;

    // W=64 instance signals
    logic        v64, ordy64, ov64, rdy64, err64, uimm64;
    logic [31:0] instr64;
    logic [63:0] imm64;
    instr_type_t typ64;
    logic [4:0]  tag64, otag64;
    logic [63:0] eimm64;
    logic        eerr64;

    exp_t q32[$];
    exp_t q64[$];
    exp_t push32, push64, pop32, pop64;

    imm_gen_pipe #(.wd_regs_p(32), .wd_tag_p(5)) u_dut32 (
        .i_clk(clk), .i_rst(rst), .i_valid(v32), .o_ready(ordy32), .i_instr(instr32),
        .i_instr_type(typ32), .i_csr_uimm(uimm32), .i_tag(tag32), .i_flush(flush32),
        .o_valid(ov32), .i_ready(rdy32), .o_imm(imm32), .o_tag(otag32), .o_err(err32)
    );

    imm_gen_pipe #(.wd_regs_p(64), .wd_tag_p(5)) u_dut64 (
        .i_clk(clk), .i_rst(rst), .i_valid(v64), .o_ready(ordy64), .i_instr(instr64),
        .i_instr_type(typ64), .i_csr_uimm(uimm64), .i_tag(tag64), .i_flush(1'b0),
        .o_valid(ov64), .i_ready(rdy64), .o_imm(imm64), .o_tag(otag64), .o_err(err64)
    );

    // Stimulus side: push the expected response when an input is accepted.
    always @(posedge clk) begin
        if (!rst && v32 && ordy32 && !flush32) begin
            push32.imm = eimm32;
            push32.tag = tag32;
            push32.err = eerr32;
            q32.push_back(push32);
        end
        if (!rst && v64 && ordy64) begin
            push64.imm = eimm64;
            push64.tag = tag64;
            push64.err = eerr64;
            q64.push_back(push64);
        end
    end

    // Monitors: compare on every output transfer; flushed entries are dropped.
    always @(negedge clk) begin
        if (!rst) begin
            if (flush32) begin
                q32.delete();
            end else if (ov32 && rdy32) begin
                checks = checks + 1;
                if (q32.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL out32_unexpected got tag=%0d imm=%h, required no output",
                             otag32, imm32);
                end else begin
                    pop32 = q32.pop_front();
                    if (imm32 !== pop32.imm[31:0] || otag32 !== pop32.tag ||
                        err32 !== pop32.err) begin
                        errors = errors + 1;
                        $display("FAIL out32 got imm=%h tag=%0d err=%b, required imm=%h tag=%0d err=%b",
                                 imm32, otag32, err32, pop32.imm[31:0], pop32.tag, pop32.err);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ov64 && rdy64) begin
            checks = checks + 1;
            if (q64.size() == 0) begin
                errors = errors + 1;
                $display("FAIL out64_unexpected got tag=%0d imm=%h, required no output",
                         otag64, imm64);
            end else begin
                pop64 = q64.pop_front();
                if (imm64 !== pop64.imm || otag64 !== pop64.tag || err64 !== pop64.err) begin
                    errors = errors + 1;
                    $display("FAIL out64 got imm=%h tag=%0d err=%b, required imm=%h tag=%0d err=%b",
                             imm64, otag64, err64, pop64.imm, pop64.tag, pop64.err);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks = checks + 1;
        if (got !== req) begin
            errors = errors + 1;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    // Offer one instruction and hold it until accepted (bounded wait).
    task automatic send(input bit wide, input logic [31:0] instr, input instr_type_t typ,
                        input logic uimm, input logic [4:0] tag, input logic [63:0] eimm,
                        input logic eerr);
        bit acc;
        if (wide) begin
            v64 = 1'b1; instr64 = instr; typ64 = typ; uimm64 = uimm; tag64 = tag;
            eimm64 = eimm; eerr64 = eerr;
        end else begin
            v32 = 1'b1; instr32 = instr; typ32 = typ; uimm32 = uimm; tag32 = tag;
            eimm32 = eimm; eerr32 = eerr;
        end
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = wide ? ordy64 : (ordy32 && !flush32);
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL accept_timeout tag=%0d got no accept, required accept", tag);
        end
    endtask

    task automatic idle();
        v32 = 1'b0;
        v64 = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        v32 = 1'b0; instr32 = '0; typ32 = InstrNone; uimm32 = 1'b0; tag32 = '0;
        flush32 = 1'b0; rdy32 = 1'b1; eimm32 = '0; eerr32 = 1'b0;
        v64 = 1'b0; instr64 = '0; typ64 = InstrNone; uimm64 = 1'b0; tag64 = '0;
        rdy64 = 1'b1; eimm64 = '0; eerr64 = 1'b0;

        #2;
        chk("rst_valid32", {63'b0, ov32}, 64'd0);
        chk("rst_ready32", {63'b0, ordy32}, 64'd1);
        chk("rst_imm32", {32'b0, imm32}, 64'd0);
        chk("rst_tag_err32", {58'b0, otag32, err32}, 64'd0);
        chk("rst_valid64", {63'b0, ov64}, 64'd0);
        chk("rst_imm64", imm64, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // W=32 format vectors, back-to-back with i_ready high
        send(0, 32'hFFF00093, InstrI,  1'b0, 5'd1,  64'hFFFFFFFF, 1'b0);
        send(0, 32'hFFF00093, InstrI,  1'b1, 5'd2,  64'h00000000, 1'b0);
        send(0, 32'h000FD073, InstrI,  1'b1, 5'd3,  64'h0000001F, 1'b0);
        send(0, 32'hFE000EE3, InstrB,  1'b0, 5'd4,  64'hFFFFFFFC, 1'b0);
        send(0, 32'h02009093, InstrIS, 1'b0, 5'd5,  64'h00000000, 1'b1);
        send(0, 32'h00509093, InstrIS, 1'b0, 5'd6,  64'h00000005, 1'b0);
        send(0, 32'hFE112E23, InstrS,  1'b1, 5'd7,  64'hFFFFFFFC, 1'b0);
        send(0, 32'h12345037, InstrU,  1'b0, 5'd8,  64'h12345000, 1'b0);
        send(0, 32'h0080006F, InstrJ,  1'b0, 5'd9,  64'h00000008, 1'b0);
        send(0, 32'h00812083, InstrIL, 1'b0, 5'd10, 64'h00000008, 1'b0);
        send(0, 32'hFFC08067, InstrIJ, 1'b0, 5'd11, 64'hFFFFFFFC, 1'b0);
        send(0, 32'h00B50533, InstrR,  1'b1, 5'd12, 64'h00000000, 1'b0);
        idle();

        // W=64 vectors
        send(1, 32'h800000B7, InstrU,  1'b0, 5'd1, 64'hFFFFFFFF80000000, 1'b0);
        send(1, 32'h02009093, InstrIS, 1'b0, 5'd2, 64'h0000000000000020, 1'b0);
        send(1, 32'hFFF00093, InstrI,  1'b0, 5'd3, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        send(1, 32'h000FD073, InstrI,  1'b1, 5'd4, 64'h000000000000001F, 1'b0);
        send(1, 32'hFE000EE3, InstrB,  1'b0, 5'd5, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        idle();
        wait_cycles(3);
        chk("drain32", 64'(q32.size()), 64'd0);
        chk("drain64", 64'(q64.size()), 64'd0);

        // Backpressure: two accepted, third blocked until released
        rdy32 = 1'b0;
        send(0, 32'h00100093, InstrI, 1'b0, 5'd1, 64'h1, 1'b0);
        send(0, 32'h00200093, InstrI, 1'b0, 5'd2, 64'h2, 1'b0);
        v32 = 1'b1; instr32 = 32'h00300093; typ32 = InstrI; uimm32 = 1'b0; tag32 = 5'd3;
        eimm32 = 64'h3; eerr32 = 1'b0;
        @(negedge clk);
        chk("bp_ready_low", {63'b0, ordy32}, 64'd0);
        chk("bp_head_tag", {59'b0, otag32}, 64'd1);
        chk("bp_head_valid", {63'b0, ov32}, 64'd1);
        wait_cycles(1);
        @(negedge clk);
        chk("bp_stall_ready", {63'b0, ordy32}, 64'd0);
        chk("bp_stall_imm", {32'b0, imm32}, 64'd1);
        @(posedge clk);
        #1;
        rdy32 = 1'b1;
        send(0, 32'h00300093, InstrI, 1'b0, 5'd3, 64'h3, 1'b0);
        idle();
        wait_cycles(4);
        chk("bp_all_out", 64'(q32.size()), 64'd0);

        // Flush with both entries full and an input offered
        rdy32 = 1'b0;
        send(0, 32'h00400093, InstrI, 1'b0, 5'd4, 64'h4, 1'b0);
        send(0, 32'h00500093, InstrI, 1'b0, 5'd5, 64'h5, 1'b0);
        v32 = 1'b1; instr32 = 32'h00700093; tag32 = 5'd7; eimm32 = 64'h7;
        flush32 = 1'b1;
        @(posedge clk);
        #1;
        flush32 = 1'b0;
        v32 = 1'b0;
        @(negedge clk);
        chk("flush_valid", {63'b0, ov32}, 64'd0);
        chk("flush_ready", {63'b0, ordy32}, 64'd1);
        rdy32 = 1'b1;
        wait_cycles(3);

        // Asynchronous reset between edges with two entries held
        rdy32 = 1'b0;
        send(0, 32'h00800093, InstrI, 1'b0, 5'd8, 64'h8, 1'b0);
        send(0, 32'h00900093, InstrI, 1'b0, 5'd9, 64'h9, 1'b0);
        idle();
        @(negedge clk);
        chk("pre_rst_full", {62'b0, ov32, ordy32}, 64'd2);
        @(posedge clk);
        #3;
        rst = 1'b1;
        q32.delete();
        q64.delete();
        #1;
        chk("async_rst_valid", {63'b0, ov32}, 64'd0);
        chk("async_rst_imm", {32'b0, imm32}, 64'd0);
        chk("async_rst_tag_err", {58'b0, otag32, err32}, 64'd0);
        chk("async_rst_ready", {63'b0, ordy32}, 64'd1);
        #2;
        rst = 1'b0;
        rdy32 = 1'b1;
        send(0, 32'hFFF00093, InstrIS, 1'b0, 5'd10, 64'h1F, 1'b1);
        send(0, 32'h00A00093, InstrI,  1'b0, 5'd11, 64'hA, 1'b0);
        idle();
        wait_cycles(3);
        chk("post_rst_drain", 64'(q32.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered immediate generator for the decode stage. It extracts, assembles and sign/zero-extends the immediate directly from the raw 32-bit instruction word for RV32 or RV64 datapaths. Both sides use valid/ready handshakes through a 2-entry skid buffer, so decode-to-execute stays fully pipelined at one instruction per cycle. It carries a sideband tag and flags illegal shift amounts. It uses `instr_type_t` from `arriskv_pkg` and sits between the instruction decoder and the register-read/execute stage.

## Interface
Parameters:
- `wd_regs_p`, default 32: datapath width; only 32 or 64 are legal, any other value is an elaboration error.
- `wd_tag_p`, default 5: width of the opaque sideband tag carried with each immediate.

Ports (one clock; reset is asynchronous and active-high):
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_valid`  in  1  upstream has an instruction.
- `o_ready`  out  1  block can accept an input this cycle.
- `i_instr`  in  32  raw instruction word.
- `i_instr_type`  in  `instr_type_t`  decoded format.
- `i_csr_uimm`  in  1  when the type is I, selects CSR zimm form.
- `i_tag`  in  `wd_tag_p`  sideband, passed unchanged.
- `i_flush`  in  1  synchronous pipeline flush.
- `o_valid`  out  1  output entry valid.
- `i_ready`  in  1  downstream accepts.
- `o_imm`  out  `wd_regs_p`  extended immediate.
- `o_tag`  out  `wd_tag_p`  tag of the output entry.
- `o_err`  out  1  illegal shift amount for the output entry.

## Operation
Immediate formation is combinational on the input side and captured on accept. Notation: sext/zext to `wd_regs_p`.
- I, IJ, IL: sext(`instr[31:20]`).
- I with `i_csr_uimm`=1: zext(`instr[19:15]`).
- S: sext({`instr[31:25]`, `instr[11:7]`}).
- B: sext({`instr[31]`, `instr[7]`, `instr[30:25]`, `instr[11:8]`, 0}).
- U: sext({`instr[31:12]`, 12'b0}). Bits above 31 replicate `instr[31]` when W=64.
- J: sext({`instr[31]`, `instr[19:12]`, `instr[20]`, `instr[30:21]`, 0}).
- IS:
  - W=64: zext(`instr[25:20]`).
  - W=32: zext(`instr[24:20]`), with `err` = `instr[25]`.
- Any other type: imm=0, err=0.
- `i_csr_uimm` is ignored for all types other than I.

Buffering:
- Two entries, main (drives outputs) and skid; each holds {imm, tag, err, valid}.
- Input transfer when `i_valid & o_ready`; output transfer when `o_valid & i_ready`.
- `o_ready` = !skid.valid (registered state, no combinational path from `i_ready`).
- Input accepted, and main is empty or main is transferring out: the new data goes to main.
- Input accepted, main is full and stalled: the new data goes to skid.
- Output transfer while skid is full: skid moves to main and skid empties.
- Order is strictly FIFO; no entry is dropped or duplicated.

Flush:
- `i_flush`=1: main.valid and skid.valid are cleared at the next edge.
- Any input offered in the same cycle is discarded, even if `o_ready`=1. Flush has priority over every transfer.
- Output transfers in a flush cycle still count downstream only if `i_ready`=1. The downstream side must treat them as squashed.

## Timing
- Reset (asynchronous, immediate):
  - `o_valid`=0, `o_imm`=0, `o_tag`=0, `o_err`=0.
  - Skid is empty, so `o_ready`=1.
- Latency: an input accepted at edge N appears with `o_valid`=1 after edge N, i.e. 1 cycle.
- Throughput: 1 transfer per cycle when `i_ready` is held high.
- `o_imm`, `o_tag`, `o_err` are stable while `o_valid`=1 and `i_ready`=0.
- Boundary cases:
  - Both entries full with `i_ready`=0: `o_ready`=0, nothing changes.
  - Both entries full with `i_ready`=1: skid moves to main; `o_ready` returns to 1 the next cycle.
  - Both entries empty: `o_valid`=0 and `o_imm` holds its last value (don't-care).
  - Simultaneous input and output transfer on a single full main entry: main is replaced, skid stays empty.
- Reset asserted mid-operation: all entries are lost immediately; outputs take their reset values.

## Test plan
- W=32, `0xFFF00093` type I → `o_imm`=`0xFFFFFFFF`. The same word with `i_csr_uimm`=1 → `0x00000000`. `0x000FD073` type I, `i_csr_uimm`=1 → `0x0000001F`.
- W=32, `0xFE000EE3` type B → `0xFFFFFFFC`. W=64, `0x800000B7` type U → `0xFFFFFFFF80000000`.
- Shift amount:
  - W=32, `0x02009093` type IS → `o_imm`=0, `o_err`=1.
  - W=64, same word → `o_imm`=`0x20`, `o_err`=0.
  - W=32, `0x00509093` → `0x5`, `o_err`=0.
- Backpressure: hold `i_ready`=0 and offer tags 1,2,3 back-to-back. Required: tags 1 and 2 accepted, `o_ready`=0 on the 3rd cycle. Then release `i_ready` and hold tag 3 offered. Required: output tags 1, 2, 3 in order, nothing lost or duplicated.
- Flush: with both entries full, assert `i_flush` together with `i_valid` (tag 7). Required: `o_valid`=0 next cycle, tag 7 never appears, `o_ready`=1.
- Async reset asserted between clock edges with 2 entries held → outputs go to 0 and `o_valid`=0 before the next edge; normal operation resumes after release.
